// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive frame checker.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_e;

  // Bit positions inside the 3-bit frame status.
  localparam int unsigned ST_CRC_ERR = 0;
  localparam int unsigned ST_PHY_ERR = 1;
  localparam int unsigned ST_LEN_ERR = 2;

  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DLY_DEPTH = 5;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module eth_crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/gmii_rx_frame_check.sv
// GMII receive frame checker: strips preamble/SFD and FCS, checks CRC, length and
// PHY errors, and emits a marked byte stream with per-frame status and statistics.
module gmii_rx_frame_check
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rx_rst,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic [2:0]       m_status,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [2:0]       Full   = 3'(DLY_DEPTH);

  rx_state_e        state;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] len;
  logic             phy_err;
  logic             sof_pending;
  logic [2:0]       fill;
  logic [7:0]       dly [DLY_DEPTH];
  logic [2:0]       status;
  logic             shift_en;

  eth_crc32_d8 u_crc (
    .crc      (crc),
    .data     (gmii_rxd),
    .crc_next (crc_next)
  );

  assign shift_en = (state == DATA) && gmii_rx_dv;

  always_comb begin
    status             = '0;
    status[ST_CRC_ERR] = (crc != CRC_RESIDUE);
    status[ST_PHY_ERR] = phy_err;
    status[ST_LEN_ERR] = (len < MinLen) || (len > MaxLen);
  end

  // The last 4 bytes held here at end of frame are the FCS and are never emitted.
  always_ff @(posedge gmii_rx_clk) begin
    if (shift_en) begin
      dly[0] <= gmii_rxd;
      for (int i = 1; i < DLY_DEPTH; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rx_rst) begin
      // Start in DROP so a frame already in flight is ignored until dv falls.
      state       <= DROP;
      crc         <= CRC_INIT;
      len         <= '0;
      phy_err     <= 1'b0;
      sof_pending <= 1'b0;
      fill        <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_status    <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eof    <= 1'b0;
      m_status <= '0;
      unique case (state)
        IDLE, PRE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state       <= DATA;
            crc         <= CRC_INIT;
            len         <= '0;
            phy_err     <= 1'b0;
            fill        <= '0;
            sof_pending <= 1'b1;
          end else if (gmii_rxd == PREAMBLE_BYTE) begin
            state <= PRE;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            crc <= crc_next;
            if (len != '1) len <= len + 1'b1;
            if (gmii_rx_er) phy_err <= 1'b1;
            if (fill == Full) begin
              m_valid     <= 1'b1;
              m_data      <= dly[DLY_DEPTH-1];
              m_sof       <= sof_pending;
              sof_pending <= 1'b0;
            end else begin
              fill <= fill + 3'd1;
            end
          end else begin
            state <= IDLE;
            fill  <= '0;
            if (fill == Full) begin
              m_valid  <= 1'b1;
              m_data   <= dly[DLY_DEPTH-1];
              m_sof    <= sof_pending;
              m_eof    <= 1'b1;
              m_status <= status;
            end
            if ((fill == Full) && (status == '0)) good_cnt <= good_cnt + 1'b1;
            else                                  bad_cnt  <= bad_cnt + 1'b1;
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Randomized self-checking bench for gmii_rx_frame_check against a frame-level model.
module tb_gmii_rx_frame_check;

  logic        clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_sof;
  logic        m_eof;
  logic [2:0]  m_status;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_frame_check #(
    .MIN_LEN (64),
    .MAX_LEN (1522),
    .CNT_W   (16)
  ) dut (
    .gmii_rx_clk (clk),
    .rx_rst      (rx_rst),
    .gmii_rxd    (rxd),
    .gmii_rx_dv  (dv),
    .gmii_rx_er  (er),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_status    (m_status),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  // Stream entries are {status, eof, sof, data}.
  logic [12:0] out_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  cur_frame[$];
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad = 16'd0;
  int          sof_cyc = -1;
  int          byte0_edge = 0;
  int          idle_viol = 0;

  always @(negedge clk) begin
    if (!rx_rst) begin
      if (m_valid) begin
        out_q.push_back({m_status, m_eof, m_sof, m_data});
        if (m_sof && sof_cyc < 0) sof_cyc = cyc;
      end else if (m_sof || m_eof || m_status != 3'b000) begin
        idle_viol++;
      end
    end
  end

  function automatic logic [31:0] crc32_std(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Number of positions where captured and expected streams disagree (incl. length).
  function automatic int stream_diff();
    int n;
    int m;
    n = (out_q.size() > exp_q.size()) ? out_q.size() - exp_q.size()
                                      : exp_q.size() - out_q.size();
    m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (out_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic make_frame(input int n_data);
    logic [31:0] fcs;
    cur_frame.delete();
    for (int i = 0; i < n_data; i++) cur_frame.push_back(8'($urandom));
    fcs = crc32_std(cur_frame, n_data);
    for (int i = 0; i < 4; i++) cur_frame.push_back(fcs[8*i +: 8]);
  endtask

  // Frame-level model: strip FCS, flag errors from the frame's own contents.
  task automatic expect_frame(input int er_idx);
    int          len;
    logic [2:0]  st;
    logic [31:0] rx_fcs;
    len = cur_frame.size();
    if (len < 5) begin
      exp_bad++;
    end else begin
      rx_fcs = {cur_frame[len-1], cur_frame[len-2], cur_frame[len-3], cur_frame[len-4]};
      st[2] = (len < 64) || (len > 1522);
      st[1] = (er_idx >= 0) && (er_idx < len);
      st[0] = crc32_std(cur_frame, len - 4) != rx_fcs;
      for (int i = 0; i < len - 4; i++)
        exp_q.push_back({(i == len - 5) ? st : 3'b000, i == len - 5, i == 0, cur_frame[i]});
      if (st == 3'b000) exp_good++;
      else              exp_bad++;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    dv  = v;
    rxd = d;
    er  = e;
  endtask

  task automatic send_frame(input int pre_len, input int er_idx, input int ifg);
    for (int i = 0; i < pre_len; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < cur_frame.size(); i++) begin
      drive(1'b1, cur_frame[i], i == er_idx);
      if (i == 0) byte0_edge = cyc + 1;
    end
    for (int i = 0; i < ifg; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_streams();
    out_q.delete();
    exp_q.delete();
    sof_cyc = -1;
  endtask

  task automatic test_reset();
    rx_rst = 1'b1;
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    rx_rst = 1'b0;
    settle();
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", m_valid);
    else n_pass++;
    n_checks++;
    if ({m_sof, m_eof, m_status} !== 5'b0) $display("FAIL reset_flags got=%b want=0",
                                                    {m_sof, m_eof, m_status});
    else n_pass++;
    n_checks++;
    if (m_data !== 8'h00) $display("FAIL reset_data got=%h want=00", m_data);
    else n_pass++;
    n_checks++;
    if (good_cnt !== 16'd0) $display("FAIL reset_good got=%0d want=0", good_cnt);
    else n_pass++;
    n_checks++;
    if (bad_cnt !== 16'd0) $display("FAIL reset_bad got=%0d want=0", bad_cnt);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_good_frame();
    int d;
    make_frame(60);
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (out_q.size() !== 60) $display("FAIL good_bytes got=%0d want=60", out_q.size());
    else n_pass++;
    n_checks++;
    if (d !== 0) $display("FAIL good_stream diffs=%0d want=0", d);
    else n_pass++;
    n_checks++;
    if (sof_cyc - byte0_edge !== 5) $display("FAIL good_latency got=%0d want=5",
                                             sof_cyc - byte0_edge);
    else n_pass++;
    n_checks++;
    if (good_cnt !== exp_good) $display("FAIL good_cnt got=%0d want=%0d", good_cnt, exp_good);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_crc_err();
    int d;
    make_frame(60);
    cur_frame[10] = cur_frame[10] ^ 8'h01;
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0) $display("FAIL crc_stream diffs=%0d want=0", d);
    else n_pass++;
    n_checks++;
    if (out_q.size() == 0 || out_q[out_q.size()-1][12:10] !== 3'b001)
      $display("FAIL crc_status got=%b want=001",
               out_q.size() == 0 ? 3'bxxx : out_q[out_q.size()-1][12:10]);
    else n_pass++;
    n_checks++;
    if (bad_cnt !== exp_bad) $display("FAIL crc_bad_cnt got=%0d want=%0d", bad_cnt, exp_bad);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_phy_err();
    int d;
    make_frame(60);
    expect_frame(30);
    send_frame(7, 30, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0) $display("FAIL phy_stream diffs=%0d want=0", d);
    else n_pass++;
    n_checks++;
    if (out_q.size() == 0 || out_q[out_q.size()-1][12:10] !== 3'b010)
      $display("FAIL phy_status got=%b want=010",
               out_q.size() == 0 ? 3'bxxx : out_q[out_q.size()-1][12:10]);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_length();
    int d;
    make_frame(56);
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    n_checks++;
    if (out_q.size() == 0 || out_q[out_q.size()-1][12:10] !== 3'b100)
      $display("FAIL short_status got=%b want=100",
               out_q.size() == 0 ? 3'bxxx : out_q[out_q.size()-1][12:10]);
    else n_pass++;
    clear_streams();
    // 3-byte frame: nothing emitted, one bad frame.
    cur_frame.delete();
    for (int i = 0; i < 3; i++) cur_frame.push_back(8'($urandom));
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    n_checks++;
    if (out_q.size() !== 0) $display("FAIL tiny_bytes got=%0d want=0", out_q.size());
    else n_pass++;
    n_checks++;
    if (bad_cnt !== exp_bad) $display("FAIL tiny_bad_cnt got=%0d want=%0d", bad_cnt, exp_bad);
    else n_pass++;
    clear_streams();
    // 5-byte frame: single byte with SOF and EOF together.
    make_frame(1);
    expect_frame(-1);
    send_frame(3, -1, 1);
    settle();
    n_checks++;
    if (out_q.size() !== 1 || out_q[0][9:8] !== 2'b11)
      $display("FAIL len5_sof_eof got=%0d bytes flags=%b want=1 bytes flags=11",
               out_q.size(), out_q.size() == 0 ? 2'bxx : out_q[0][9:8]);
    else n_pass++;
    clear_streams();
    make_frame(1526);
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0) $display("FAIL long_stream diffs=%0d want=0", d);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_bad_preamble();
    int d;
    logic [15:0] g0;
    logic [15:0] b0;
    g0 = good_cnt;
    b0 = bad_cnt;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    settle();
    n_checks++;
    if (out_q.size() !== 0 || good_cnt !== g0 || bad_cnt !== b0)
      $display("FAIL badpre_quiet got=%0d bytes good=%0d bad=%0d want=0 bytes good=%0d bad=%0d",
               out_q.size(), good_cnt, bad_cnt, g0, b0);
    else n_pass++;
    make_frame(70);
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0 || good_cnt !== exp_good)
      $display("FAIL badpre_next diffs=%0d good=%0d want diffs=0 good=%0d", d, good_cnt, exp_good);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_reset_mid();
    int d;
    make_frame(60);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < cur_frame.size(); i++) begin
      drive(1'b1, cur_frame[i], 1'b0);
      if (i == 30) begin
        out_q.delete();
        rx_rst = 1'b1;
      end
      if (i == 32) rx_rst = 1'b0;
    end
    drive(1'b0, 8'h00, 1'b0);
    settle();
    n_checks++;
    if (out_q.size() !== 0) $display("FAIL rstmid_bytes got=%0d want=0", out_q.size());
    else n_pass++;
    n_checks++;
    if (good_cnt !== 16'd0 || bad_cnt !== 16'd0)
      $display("FAIL rstmid_cnt got good=%0d bad=%0d want 0/0", good_cnt, bad_cnt);
    else n_pass++;
    clear_streams();
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    make_frame(60);
    expect_frame(-1);
    send_frame(7, -1, 1);
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0 || good_cnt !== 16'd1)
      $display("FAIL rstmid_next diffs=%0d good=%0d want diffs=0 good=1", d, good_cnt);
    else n_pass++;
    clear_streams();
  endtask

  task automatic test_back_to_back();
    int d;
    int er_idx;
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 5) == 0) begin
        cur_frame.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) cur_frame.push_back(8'($urandom));
      end else begin
        make_frame($urandom_range(1, 116));
        if ($urandom_range(0, 3) == 0)
          cur_frame[0] = cur_frame[0] ^ 8'(1 << $urandom_range(0, 7));
      end
      er_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, cur_frame.size() - 1)) : -1;
      expect_frame(er_idx);
      send_frame($urandom_range(0, 7), er_idx, 1);
    end
    settle();
    d = stream_diff();
    n_checks++;
    if (d !== 0) $display("FAIL b2b_stream diffs=%0d want=0 (got %0d entries, want %0d)",
                          d, out_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (good_cnt !== exp_good || bad_cnt !== exp_bad)
      $display("FAIL b2b_cnt got good=%0d bad=%0d want good=%0d bad=%0d",
               good_cnt, bad_cnt, exp_good, exp_bad);
    else n_pass++;
    n_checks++;
    if (idle_viol !== 0) $display("FAIL idle_flags got=%0d want=0", idle_viol);
    else n_pass++;
    clear_streams();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_err();
    test_phy_err();
    test_length();
    test_bad_preamble();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
